// File: rtl/column_buffer_ctrl_if.sv
// rtl/column_buffer_ctrl_if.sv - bus bundle for the column buffer controller
// Purpose: groups the Avalon-style beat input, the VGA line counter and the
// column-buffer write/status outputs of column_buffer_ctrl.
// Signals:
//   chipselect, write, writedata[15:0] : beat input, accepted when chipselect && write
//   vcount[9:0]                        : current display line
//   col_wr_en[2:0], col_wr_num[9:0],
//   col_wr_data[41:0], col_wr_sf[15:0] : column record write port
//   rd_buf[1:0], wr_buf[1:0]           : display / fill buffer indices
//   frame_pending, swap_pulse,
//   frames_dropped[7:0]                : triple-buffer status
// Modports: master drives beats and vcount, slave is the controller.
interface column_buffer_ctrl_if;
  logic        chipselect;
  logic        write;
  logic [15:0] writedata;
  logic [9:0]  vcount;
  logic [2:0]  col_wr_en;
  logic [9:0]  col_wr_num;
  logic [41:0] col_wr_data;
  logic [15:0] col_wr_sf;
  logic [1:0]  rd_buf;
  logic [1:0]  wr_buf;
  logic        frame_pending;
  logic        swap_pulse;
  logic [7:0]  frames_dropped;

  modport master (
    output chipselect, write, writedata, vcount,
    input  col_wr_en, col_wr_num, col_wr_data, col_wr_sf,
    input  rd_buf, wr_buf, frame_pending, swap_pulse, frames_dropped
  );

  modport slave (
    input  chipselect, write, writedata, vcount,
    output col_wr_en, col_wr_num, col_wr_data, col_wr_sf,
    output rd_buf, wr_buf, frame_pending, swap_pulse, frames_dropped
  );
endinterface

// File: rtl/column_buffer_ctrl.sv
// rtl/column_buffer_ctrl.sv - four-beat column assembler with triple-buffer swap control
// Purpose: assembles four 16-bit beats into one column record, writes it to
// the column buffer currently being filled, and rotates three buffers
// (display, fill, pending) with swaps allowed once per frame at SWAP_LINE.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : column_buffer_ctrl_if.slave (beats, vcount, write port, status)
// Parameters: NCOLS columns per frame, SWAP_LINE vcount that permits a swap.
module column_buffer_ctrl #(
  parameter int NCOLS     = 640,
  parameter int SWAP_LINE = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  column_buffer_ctrl_if.slave  bus
);

  localparam logic [9:0] LAST_COL = 10'(NCOLS - 1);
  localparam logic [9:0] SWAP_V   = 10'(SWAP_LINE);

  typedef enum logic [1:0] {S0, S1, S2, S3} beat_state_t;

  beat_state_t state_q, state_d;

  logic [9:0]  w0_q;
  logic [15:0] w1_q, w2_q;
  logic [9:0]  col_q;
  logic [9:0]  vcount_q;

  logic [2:0]  col_wr_en_q;
  logic [9:0]  col_wr_num_q;
  logic [41:0] col_wr_data_q;
  logic [15:0] col_wr_sf_q;

  logic [1:0]  rd_q, wr_q, pend_q;
  logic [1:0]  rd_d, wr_d, pend_d;
  logic        pending_q, pending_d;
  logic        pulse_q, pulse_d;
  logic [7:0]  dropped_q, dropped_d;

  logic beat;
  logic last_beat;
  logic frame_done;
  logic swap_evt;

  assign beat       = bus.chipselect && bus.write;
  assign last_beat  = beat && (state_q == S3);
  assign frame_done = last_beat && (col_q == LAST_COL);
  // Edge detect on vcount so a line held at SWAP_LINE swaps only once.
  assign swap_evt   = (bus.vcount == SWAP_V) && (vcount_q != SWAP_V);

  always_comb begin
    state_d = state_q;
    if (beat) begin
      case (state_q)
        S0: state_d = S1;
        S1: state_d = S2;
        S2: state_d = S3;
        S3: state_d = S0;
        default: state_d = S0;
      endcase
    end
  end

  // Buffer rotation. pend_q always holds the third index, so it doubles as
  // the spare buffer whenever nothing is pending.
  always_comb begin
    rd_d      = rd_q;
    wr_d      = wr_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    dropped_d = dropped_q;
    pulse_d   = 1'b0;
    if (frame_done && swap_evt && pending_q) begin
      // Display the pending frame, park the just-finished one as pending,
      // and refill the buffer that was on screen.
      rd_d    = pend_q;
      pend_d  = wr_q;
      wr_d    = rd_q;
      pulse_d = 1'b1;
    end else if (frame_done && !pending_q) begin
      pend_d    = wr_q;
      wr_d      = pend_q;
      pending_d = 1'b1;
    end else if (frame_done) begin
      // Undisplayed pending frame is overwritten by the newer one.
      wr_d   = pend_q;
      pend_d = wr_q;
      if (dropped_q != 8'hFF) begin
        dropped_d = dropped_q + 8'd1;
      end
    end else if (swap_evt && pending_q) begin
      rd_d      = pend_q;
      pend_d    = rd_q;
      pending_d = 1'b0;
      pulse_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S0;
      w0_q          <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
      col_q         <= '0;
      vcount_q      <= '0;
      col_wr_en_q   <= '0;
      col_wr_num_q  <= '0;
      col_wr_data_q <= '0;
      col_wr_sf_q   <= '0;
      rd_q          <= 2'd0;
      wr_q          <= 2'd1;
      pend_q        <= 2'd2;
      pending_q     <= 1'b0;
      pulse_q       <= 1'b0;
      dropped_q     <= '0;
    end else begin
      state_q   <= state_d;
      vcount_q  <= bus.vcount;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      pulse_q   <= pulse_d;
      dropped_q <= dropped_d;

      col_wr_en_q <= 3'b000;
      if (beat) begin
        case (state_q)
          S0: w0_q <= bus.writedata[9:0];
          S1: w1_q <= bus.writedata;
          S2: w2_q <= bus.writedata;
          default: ;
        endcase
      end
      if (last_beat) begin
        col_wr_en_q   <= 3'b001 << wr_q;
        col_wr_num_q  <= col_q;
        col_wr_data_q <= {w2_q, w1_q, w0_q};
        col_wr_sf_q   <= bus.writedata;
        col_q         <= (col_q == LAST_COL) ? 10'd0 : col_q + 10'd1;
      end
    end
  end

  assign bus.col_wr_en      = col_wr_en_q;
  assign bus.col_wr_num     = col_wr_num_q;
  assign bus.col_wr_data    = col_wr_data_q;
  assign bus.col_wr_sf      = col_wr_sf_q;
  assign bus.rd_buf         = rd_q;
  assign bus.wr_buf         = wr_q;
  assign bus.frame_pending  = pending_q;
  assign bus.swap_pulse     = pulse_q;
  assign bus.frames_dropped = dropped_q;

endmodule

// File: tb/tb_column_buffer_ctrl.sv
// tb/tb_column_buffer_ctrl.sv - self-checking bench for column_buffer_ctrl
module tb_column_buffer_ctrl;
  localparam int NCOLS     = 640;
  localparam int SWAP_LINE = 480;

  logic clk;
  logic reset;
  column_buffer_ctrl_if bus ();

  column_buffer_ctrl #(.NCOLS(NCOLS), .SWAP_LINE(SWAP_LINE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: beats collected in a queue, buffers as plain ints.
  logic [15:0] q[$];
  int          m_col, m_rd, m_wr, m_pend, m_drop, m_frames;
  bit          m_pending, m_pulse;
  logic [9:0]  m_prev;
  logic [2:0]  m_en;
  logic [9:0]  m_num;
  logic [41:0] m_data;
  logic [15:0] m_sf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_col = 0; m_rd = 0; m_wr = 1; m_pend = 2; m_drop = 0;
    m_pending = 0; m_pulse = 0; m_prev = '0;
    m_en = '0; m_num = '0; m_data = '0; m_sf = '0;
  endtask

  task automatic model_step(input bit b, input logic [15:0] wd, input logic [9:0] vc);
    bit done, swap;
    int o_rd, o_wr, o_pend;
    logic [15:0] w0;
    done = 0; m_en = '0; m_pulse = 0;
    if (b) begin
      q.push_back(wd);
      if (q.size() == 4) begin
        w0     = q[0];
        m_en   = 3'(1 << m_wr);
        m_data = {q[2], q[1], w0[9:0]};
        m_sf   = q[3];
        m_num  = 10'(m_col);
        done   = (m_col == NCOLS - 1);
        m_col  = done ? 0 : m_col + 1;
        q.delete();
      end
    end
    swap   = (int'(vc) == SWAP_LINE) && (int'(m_prev) != SWAP_LINE);
    m_prev = vc;
    o_rd = m_rd; o_wr = m_wr; o_pend = m_pend;
    if (done && swap && m_pending) begin
      m_rd = o_pend; m_pend = o_wr; m_wr = o_rd; m_pulse = 1;
    end else if (done && !m_pending) begin
      m_pend = o_wr; m_wr = 3 ^ o_rd ^ o_wr; m_pending = 1;
    end else if (done) begin
      m_wr = o_pend; m_pend = o_wr;
      if (m_drop < 255) m_drop++;
    end else if (swap && m_pending) begin
      m_rd = o_pend; m_pend = o_rd; m_pending = 0; m_pulse = 1;
    end
    if (done) m_frames++;
  endtask

  task automatic compare_all();
    check("col_wr_en",      64'(bus.col_wr_en),      64'(m_en));
    check("col_wr_num",     64'(bus.col_wr_num),     64'(m_num));
    check("col_wr_data",    64'(bus.col_wr_data),    64'(m_data));
    check("col_wr_sf",      64'(bus.col_wr_sf),      64'(m_sf));
    check("rd_buf",         64'(bus.rd_buf),         64'(m_rd));
    check("wr_buf",         64'(bus.wr_buf),         64'(m_wr));
    check("frame_pending",  64'(bus.frame_pending),  64'(m_pending));
    check("swap_pulse",     64'(bus.swap_pulse),     64'(m_pulse));
    check("frames_dropped", 64'(bus.frames_dropped), 64'(m_drop));
  endtask

  task automatic cycle(input bit cs, input bit wr, input logic [15:0] wd, input logic [9:0] vc);
    @(negedge clk);
    bus.chipselect = cs; bus.write = wr; bus.writedata = wd; bus.vcount = vc;
    @(posedge clk);
    model_step(cs && wr, wd, vc);
    #1 compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.chipselect = 0; bus.write = 0; bus.vcount = '0;
    reset = 1'b1;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rnd_cycle(input logic [9:0] vc);
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) cycle(1, 1, 16'($urandom), vc);
    else cycle(1'($urandom), (r == 9) ? 1'b0 : 1'b1, 16'($urandom), vc) ;
  endtask

  task automatic fill_frame(input logic [9:0] vc);
    int start, guard;
    start = m_frames; guard = 0;
    while (m_frames == start && guard < 20000) begin
      rnd_cycle(vc);
      guard++;
    end
    if (guard >= 20000) check("fill_timeout", 64'(1), 64'(0));
  endtask

  initial begin
    int guard;
    logic [9:0] vc;
    m_frames = 0;
    reset = 1'b1;
    bus.chipselect = 0; bus.write = 0; bus.writedata = '0; bus.vcount = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 compare_all();
    @(negedge clk) reset = 1'b0;

    // First column record and its buffer/number/data.
    cycle(1, 1, 16'h03FF, 10'd0);
    cycle(1, 1, 16'h1234, 10'd0);
    cycle(1, 1, 16'h8001, 10'd0);
    cycle(1, 1, 16'h0200, 10'd0);
    check("first_en",   64'(bus.col_wr_en),   64'(3'b010));
    check("first_data", 64'(bus.col_wr_data), 64'({16'h8001, 16'h1234, 10'h3FF}));
    check("first_sf",   64'(bus.col_wr_sf),   64'(16'h0200));
    cycle(0, 0, 16'h0, 10'd0);
    check("en_one_cycle", 64'(bus.col_wr_en), 64'(3'b000));

    // Full frame, then swap at the swap line.
    do_reset();
    fill_frame(10'd0);
    check("last_num", 64'(bus.col_wr_num), 64'(10'd639));
    check("last_en",  64'(bus.col_wr_en),  64'(3'b010));
    check("pend_set", 64'(bus.frame_pending), 64'(1));
    check("wr_after_frame", 64'(bus.wr_buf), 64'(2));
    repeat (4) cycle(1, 1, 16'($urandom), 10'd0);
    check("next_en",  64'(bus.col_wr_en),  64'(3'b100));
    check("next_num", 64'(bus.col_wr_num), 64'(0));
    cycle(0, 0, 16'h0, 10'd479);
    cycle(0, 0, 16'h0, 10'd480);
    check("swap_pulse_hi", 64'(bus.swap_pulse), 64'(1));
    check("swap_rd",       64'(bus.rd_buf),     64'(1));
    cycle(0, 0, 16'h0, 10'd480);
    cycle(0, 0, 16'h0, 10'd480);
    check("swap_pulse_once", 64'(bus.swap_pulse), 64'(0));

    // Two frames with no swap: one drop, write buffers alternate.
    do_reset();
    fill_frame(10'd0);
    fill_frame(10'd0);
    check("drop_count", 64'(bus.frames_dropped), 64'(1));
    check("drop_rd",    64'(bus.rd_buf),         64'(0));
    check("drop_wr",    64'(bus.wr_buf),         64'(1));

    // Last column beat coincides with the swap line, pending set.
    guard = 0;
    while (!(m_col == NCOLS - 1 && q.size() == 3) && guard < 20000) begin
      rnd_cycle(10'd479);
      guard++;
    end
    if (guard >= 20000) check("sim_timeout", 64'(1), 64'(0));
    cycle(1, 1, 16'($urandom), 10'd480);
    check("sim_rd",      64'(bus.rd_buf),         64'(2));
    check("sim_wr",      64'(bus.wr_buf),         64'(0));
    check("sim_pending", 64'(bus.frame_pending),  64'(1));
    check("sim_drop",    64'(bus.frames_dropped), 64'(1));
    check("sim_pulse",   64'(bus.swap_pulse),     64'(1));

    // Reset in mid-column discards partial beats.
    cycle(1, 1, 16'hDEAD, 10'd0);
    cycle(1, 1, 16'hBEEF, 10'd0);
    do_reset();
    cycle(1, 1, 16'h0155, 10'd0);
    cycle(1, 1, 16'hAAAA, 10'd0);
    cycle(1, 1, 16'h5555, 10'd0);
    check("rst_mid_noen", 64'(bus.col_wr_en), 64'(3'b000));
    cycle(1, 1, 16'h0001, 10'd0);
    check("rst_mid_en",   64'(bus.col_wr_en),   64'(3'b010));
    check("rst_mid_num",  64'(bus.col_wr_num),  64'(0));
    check("rst_mid_data", 64'(bus.col_wr_data), 64'({16'h5555, 16'hAAAA, 10'h155}));

    // Random traffic against a sweeping, occasionally jumping vcount.
    do_reset();
    vc = '0;
    for (int i = 0; i < 14000; i++) begin
      if ($urandom_range(0, 199) == 0) vc = 10'($urandom_range(470, 490));
      else vc = (vc >= 10'd524) ? 10'd0 : vc + 10'd1;
      rnd_cycle(vc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/column_buffer_ctrl.md
COLUMN_BUFFER_CTRL -- requirements
Module: column_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter NCOLS, default 640, meaning the number of columns per frame.
REQ-002 The block SHALL have parameter SWAP_LINE, default 480, meaning the vcount value at which a buffer swap is permitted.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port chipselect, input, 1 bit: Avalon slave select.
REQ-006 Port write, input, 1 bit: Avalon write strobe; a beat is accepted on any cycle with chipselect && write, with no backpressure.
REQ-007 Port writedata, input, 16 bits: beat payload.
REQ-008 Port vcount, input, 10 bits: current display line from the VGA counters.
REQ-009 Port col_wr_en, output, 3 bits: one-hot write strobe, one bit per column buffer.
REQ-010 Port col_wr_num, output, 10 bits: column index for the write.
REQ-011 Port col_wr_data, output, 42 bits: assembled column record.
REQ-012 Port col_wr_sf, output, 16 bits: scaling factor for the write.
REQ-013 Port rd_buf, output, 2 bits: index of the buffer being displayed.
REQ-014 Port wr_buf, output, 2 bits: index of the buffer being filled.
REQ-015 Port frame_pending, output, 1 bit: a completed frame is awaiting swap.
REQ-016 Port swap_pulse, output, 1 bit: one-cycle pulse when rd_buf changes.
REQ-017 Port frames_dropped, output, 8 bits: saturating count of completed frames overwritten before display.

Function
REQ-018 Beat-assembly FSM SHALL have states S0..S3; each accepted beat advances one state (S3 to S0); non-beat cycles hold state.
REQ-019 S0 SHALL capture writedata[9:0] as w0; S1 SHALL capture writedata as w1; S2 SHALL capture writedata as w2.
REQ-020 The beat accepted in S3 (cycle N) SHALL, on the edge ending N, register col_wr_data={w2,w1,w0}, col_wr_sf=writedata, col_wr_num=column counter, and col_wr_en=one-hot(wr_buf value before this edge).
REQ-021 col_wr_en SHALL be high for exactly one cycle (N+1) per column; otherwise 3'b000; data/num/sf hold between writes.
REQ-022 Column counter: increments per S3 beat; at NCOLS-1 it wraps to 0 and signals frame complete on the same edge.
REQ-023 Buffers 0..2 SHALL be three distinct indices rd_buf, wr_buf, pend_buf; spare = 3 ^ rd_buf ^ wr_buf when not pending.
REQ-024 Swap event SHALL be vcount==SWAP_LINE while the registered previous vcount != SWAP_LINE (once per frame).
REQ-025 Frame complete, no pending: pend_buf<=wr_buf, wr_buf<=spare, frame_pending<=1.
REQ-026 Frame complete, pending set: wr_buf and pend_buf SHALL exchange; frames_dropped increments, saturating at 255.
REQ-027 Swap event with pending: rd_buf<=pend_buf, wr_buf unchanged, old rd_buf becomes spare, frame_pending<=0, swap_pulse<=1.
REQ-028 Swap event without pending: no change, swap_pulse stays 0.
REQ-029 Simultaneous complete and swap with pending set: rd_buf<=pend_buf, pend_buf<=wr_buf, wr_buf<=old rd_buf, frame_pending stays 1, swap_pulse=1, no drop counted.
REQ-030 Simultaneous complete and swap with pending clear: complete handled per REQ-025; swap deferred to next swap event.
REQ-031 rd_buf, wr_buf, and pend_buf SHALL never be equal to one another, and none SHALL be 3.

Reset
REQ-032 On reset assertion, the block SHALL asynchronously set: FSM=S0, column counter=0, rd_buf=0, wr_buf=1, pend_buf=2, frame_pending=0, swap_pulse=0, col_wr_en=0, col_wr_num=0, col_wr_data=0, col_wr_sf=0, frames_dropped=0, previous-vcount register=0.
REQ-033 Reset mid-column SHALL discard the partially assembled beats; the first beat after reset is S0.

Verification
REQ-034 Reset, then 4 beats 0x03FF,0x1234,0x8001,0x0200 -> one cycle later col_wr_en=3'b010, col_wr_num=0, col_wr_data={0x8001,0x1234,0x3FF}, col_wr_sf=0x0200.
REQ-035 640 columns (2560 beats) -> last write num=639 to buffer 1; frame_pending=1, wr_buf=2; next column num=0 to buffer 2.
REQ-036 After REQ-035, vcount steps 479->480 -> swap_pulse for 1 cycle, rd_buf=1, frame_pending=0, wr_buf=2; holding vcount at 480 produces no further pulse.
REQ-037 Two full frames with no swap event -> frames_dropped=1, frame_pending=1, rd_buf=0, and the two write buffers alternate {1,2}.
REQ-038 Last column beat and vcount 479->480 on the same cycle with pending set -> rd_buf=old pend_buf, wr_buf=old rd_buf, frame_pending=1, frames_dropped unchanged.
REQ-039 Reset asserted after 2 beats, released, then 4 beats -> a single write at col 0 containing only the post-reset data.
